mtm_alu_core: RTL and testbench

Arithmetic core of the mtm_Alu, sitting between the input deserializer and the output serializer. It accepts one decoded operation (A, B, opcode, CRC4) per frame and checks the CRC and opcode. It then computes the 32-bit result, the flags and the CRC3, and presents them to the serializer with a single-cycle `t_valid` strobe. It also paces the serializer: it holds results stable and refuses new work until the outgoing frame time has elapsed.

---
 rtl/mtm_alu_core.sv | 225 ++++++++++++++++++++++
 tb/tb_mtm_alu_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_core.sv
`timescale 1ns/1ps
// mtm_alu_core
// Arithmetic core of the mtm_Alu. Accepts one decoded operation per frame,
// validates its CRC4 and opcode, computes the 32-bit result, flags and CRC3,
// and presents them to the output serializer with a one-cycle strobe. Each
// result or error strobe is followed by a hold period covering the outgoing
// serial frame. New work is refused during that period.
//
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is high only in IDLE. in_valid seen while
// in_ready is low is ignored entirely.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, in_ready  operation handshake
//   A, B, op, crc_in    operands, opcode, host CRC4
//   data_err            deserializer framing/packet error
//   C, carry, overflow, zero, negative, crc_out
//                       result bundle, stable from t_valid to next t_valid
//   t_valid             one-cycle result strobe
//   err_valid           one-cycle error strobe
//   err_flags           {ERR_DATA, ERR_CRC, ERR_OP}, held until next err_valid
//   state_dbg           current FSM state encoding
module mtm_alu_core #(
  parameter int DATA_HOLD = 55,
  parameter int ERR_HOLD  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic [3:0]  crc_in,
  input  logic        data_err,
  output logic [31:0] C,
  output logic        carry,
  output logic        overflow,
  output logic        zero,
  output logic        negative,
  output logic [2:0]  crc_out,
  output logic        t_valid,
  output logic        err_valid,
  output logic [2:0]  err_flags,
  output logic [2:0]  state_dbg
);

  localparam int MAX_HOLD = (DATA_HOLD > ERR_HOLD) ? DATA_HOLD : ERR_HOLD;
  localparam int CNT_W    = $clog2(MAX_HOLD + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EXEC  = 3'd2,
    S_EMIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Serial CRC4, MSB first, x^4+x+1, initial value 0.
  function automatic logic [3:0] crc4_f(input logic [67:0] m);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
    end
    return c;
  endfunction

  // Serial CRC3, MSB first, x^3+x+1, initial value 0.
  function automatic logic [2:0] crc3_f(input logic [36:0] m);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ m[i];
      c  = {c[1:0], 1'b0} ^ ({3{fb}} & 3'b011);
    end
    return c;
  endfunction

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic [2:0]         op_q;
  logic [3:0]         crc_in_q;
  logic               derr_q;
  logic               is_err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        c_q;
  logic               carry_q, overflow_q, zero_q, negative_q;
  logic [2:0]         crc_out_q;
  logic               t_valid_q, err_valid_q;
  logic [2:0]         err_flags_q;

  logic [2:0]         errs_d;
  logic               op_bad;
  logic [32:0]        sum_d, diff_d;
  logic [31:0]        c_d;
  logic               carry_d, overflow_d, zero_d, negative_d;
  logic [2:0]         crc_out_d;

  always_comb begin
    op_bad = !(op_q inside {3'b000, 3'b001, 3'b100, 3'b101});
    // Only the highest-priority error is reported: DATA > CRC > OP.
    errs_d = 3'b000;
    if (derr_q)                                        errs_d = 3'b100;
    else if (crc4_f({b_q, a_q, 1'b1, op_q}) != crc_in_q) errs_d = 3'b010;
    else if (op_bad)                                   errs_d = 3'b001;

    sum_d      = {1'b0, b_q} + {1'b0, a_q};
    // Bit 32 of the 33-bit difference is the borrow (B < A unsigned).
    diff_d     = {1'b0, b_q} - {1'b0, a_q};
    c_d        = 32'd0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_q)
      3'b000: c_d = a_q & b_q;
      3'b001: c_d = a_q | b_q;
      3'b100: begin
        c_d        = sum_d[31:0];
        carry_d    = sum_d[32];
        overflow_d = (a_q[31] == b_q[31]) && (sum_d[31] != b_q[31]);
      end
      3'b101: begin
        c_d        = diff_d[31:0];
        carry_d    = diff_d[32];
        overflow_d = (a_q[31] != b_q[31]) && (diff_d[31] != b_q[31]);
      end
      default: c_d = 32'd0;
    endcase
    zero_d     = (c_d == 32'd0);
    negative_d = c_d[31];
    crc_out_d  = crc3_f({c_d, 1'b0, carry_d, overflow_d, zero_d, negative_d});
  end

  // The result bundle and CRC3 are registered together at the end of EXEC so
  // that they are already valid in the EMIT cycle, where t_valid is high.
  // EMIT is also the strobe cycle on the error path, so both paths release
  // in_ready exactly (hold + 1) cycles after their strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      crc_in_q    <= '0;
      derr_q      <= 1'b0;
      is_err_q    <= 1'b0;
      cnt_q       <= '0;
      c_q         <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      crc_out_q   <= '0;
      t_valid_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_flags_q <= '0;
    end else begin
      t_valid_q   <= 1'b0;
      err_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= op;
            crc_in_q <= crc_in;
            derr_q   <= data_err;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (errs_d != 3'b000) begin
            err_valid_q <= 1'b1;
            err_flags_q <= errs_d;
            is_err_q    <= 1'b1;
          end else begin
            is_err_q    <= 1'b0;
          end
          state_q <= (errs_d != 3'b000) ? S_EMIT : S_EXEC;
        end
        S_EXEC: begin
          c_q        <= c_d;
          carry_q    <= carry_d;
          overflow_q <= overflow_d;
          zero_q     <= zero_d;
          negative_q <= negative_d;
          crc_out_q  <= crc_out_d;
          t_valid_q  <= 1'b1;
          state_q    <= S_EMIT;
        end
        S_EMIT: begin
          cnt_q   <= is_err_q ? CNT_W'(ERR_HOLD) : CNT_W'(DATA_HOLD);
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // A zero hold still spends one cycle here.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst;
  assign C         = c_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign crc_out   = crc_out_q;
  assign t_valid   = t_valid_q;
  assign err_valid = err_valid_q;
  assign err_flags = err_flags_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mtm_alu_core.sv
`timescale 1ns/1ps
module tb_mtm_alu_core;

  localparam int DATA_HOLD = 55;
  localparam int ERR_HOLD  = 11;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  op = '0;
  logic [3:0]  crc_in = '0;
  logic        data_err = 1'b0;
  logic [31:0] C;
  logic        carry, overflow, zero, negative;
  logic [2:0]  crc_out;
  logic        t_valid, err_valid;
  logic [2:0]  err_flags;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  mtm_alu_core #(.DATA_HOLD(DATA_HOLD), .ERR_HOLD(ERR_HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .crc_in(crc_in), .data_err(data_err),
    .C(C), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative),
    .crc_out(crc_out), .t_valid(t_valid), .err_valid(err_valid),
    .err_flags(err_flags), .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference CRCs by polynomial long division of m(x)*x^k.
  function automatic logic [3:0] model_crc4(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] model_crc3(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [3:0] good_crc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    return model_crc4({b, a, 1'b1, o});
  endfunction

  // ---------------- driver ----------------
  int          r_tcyc, r_ecyc, r_low, r_nt, r_ne;
  logic        r_both;
  logic [31:0] r_c;
  logic [3:0]  r_flags;
  logic [2:0]  r_crc, r_ef;

  // Issues one operation and watches the DUT cycle by cycle (k=1 is the cycle
  // after acceptance). If inject > 0, a valid-looking operation is offered on
  // cycle k == inject while the core should be busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                        input logic [3:0] crc, input logic derr, input int inject);
    int guard;
    r_tcyc = -1; r_ecyc = -1; r_low = -1; r_nt = 0; r_ne = 0; r_both = 1'b0;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    A = a; B = b; op = o; crc_in = crc; data_err = derr; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == inject) begin
        A = 32'h1111_2222; B = 32'h3333_4444; op = 3'b100; data_err = 1'b0;
        crc_in = good_crc(32'h1111_2222, 32'h3333_4444, 3'b100);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (t_valid) begin
        r_nt++;
        if (r_tcyc < 0) r_tcyc = k;
        r_c = C; r_flags = {carry, overflow, zero, negative}; r_crc = crc_out;
      end
      if (err_valid) begin
        r_ne++;
        if (r_ecyc < 0) r_ecyc = k;
        r_ef = err_flags;
      end
      if (t_valid && err_valid) r_both = 1'b1;
      if (in_ready) begin
        r_low = k - 1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (r_low < 0) check("done_timeout", 64'(r_low), 64'd0);
  endtask

  // Checks a completed good operation; flags are {carry, overflow, zero, negative}.
  task automatic expect_good(input string tag, input logic [31:0] expc, input logic [3:0] expf);
    check({tag, "_tcyc"}, 64'(r_tcyc), 64'd3);
    check({tag, "_C"},     64'(r_c), 64'(expc));
    check({tag, "_flags"}, 64'(r_flags), 64'(expf));
    check({tag, "_crc3"},  64'(r_crc), 64'(model_crc3({expc, 1'b0, expf})));
    check({tag, "_nt"},    64'(r_nt), 64'd1);
    check({tag, "_ne"},    64'(r_ne), 64'd0);
    check({tag, "_low"},   64'(r_low), 64'(DATA_HOLD + 3));
    check({tag, "_held"},  64'(C), 64'(expc));
  endtask

  task automatic expect_err(input string tag, input logic [2:0] expef, input logic [31:0] prevc,
                            input logic [3:0] prevf);
    check({tag, "_ecyc"},  64'(r_ecyc), 64'd2);
    check({tag, "_flags"}, 64'(r_ef), 64'(expef));
    check({tag, "_nt"},    64'(r_nt), 64'd0);
    check({tag, "_ne"},    64'(r_ne), 64'd1);
    check({tag, "_low"},   64'(r_low), 64'(ERR_HOLD + 2));
    check({tag, "_Ckeep"}, 64'(C), 64'(prevc));
    check({tag, "_fkeep"}, 64'({carry, overflow, zero, negative}), 64'(prevf));
    check({tag, "_efheld"}, 64'(err_flags), 64'(expef));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int nt_rst;
  logic any_both;

  initial begin
    any_both = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_C",        64'(C), 64'd0);
    check("rst_flags",    64'({carry, overflow, zero, negative}), 64'd0);
    check("rst_crc_out",  64'(crc_out), 64'd0);
    check("rst_strobes",  64'({t_valid, err_valid}), 64'd0);
    check("rst_err_flags", 64'(err_flags), 64'd0);

    run_op(32'd1, 32'd1, 3'b100, good_crc(32'd1, 32'd1, 3'b100), 1'b0, 0);
    any_both |= r_both;
    expect_good("add_1_1", 32'h0000_0002, 4'b0000);

    run_op(32'd1, 32'd0, 3'b101, good_crc(32'd1, 32'd0, 3'b101), 1'b0, 0);
    any_both |= r_both;
    expect_good("sub_0_1", 32'hFFFF_FFFF, 4'b1001);

    run_op(32'd1, 32'h7FFF_FFFF, 3'b100, good_crc(32'd1, 32'h7FFF_FFFF, 3'b100), 1'b0, 0);
    any_both |= r_both;
    expect_good("add_ovf", 32'h8000_0000, 4'b0101);

    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000, good_crc(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000), 1'b0, 0);
    any_both |= r_both;
    expect_good("and_zero", 32'h0000_0000, 4'b0010);

    run_op(32'h1234_0000, 32'h0000_5678, 3'b001, good_crc(32'h1234_0000, 32'h0000_5678, 3'b001), 1'b0, 0);
    any_both |= r_both;
    expect_good("or", 32'h1234_5678, 4'b0000);

    run_op(32'd1, 32'hFFFF_FFFF, 3'b100, good_crc(32'd1, 32'hFFFF_FFFF, 3'b100), 1'b0, 0);
    any_both |= r_both;
    expect_good("add_carry", 32'h0000_0000, 4'b1010);

    run_op(32'd1, 32'h8000_0000, 3'b101, good_crc(32'd1, 32'h8000_0000, 3'b101), 1'b0, 0);
    any_both |= r_both;
    expect_good("sub_ovf", 32'h7FFF_FFFF, 4'b0100);

    // Error paths: previous result 0x7FFFFFFF / flags 0100 must survive.
    run_op(32'd5, 32'd6, 3'b111, good_crc(32'd5, 32'd6, 3'b111), 1'b0, 0);
    any_both |= r_both;
    expect_err("err_op", 3'b001, 32'h7FFF_FFFF, 4'b0100);

    run_op(32'd5, 32'd6, 3'b100, good_crc(32'd5, 32'd6, 3'b100) ^ 4'b0001, 1'b1, 0);
    any_both |= r_both;
    expect_err("err_data", 3'b100, 32'h7FFF_FFFF, 4'b0100);

    run_op(32'd5, 32'd6, 3'b111, good_crc(32'd5, 32'd6, 3'b111) ^ 4'b1000, 1'b0, 0);
    any_both |= r_both;
    expect_err("err_crc", 3'b010, 32'h7FFF_FFFF, 4'b0100);

    // Offer a second operation mid-hold; it must be ignored.
    run_op(32'd3, 32'd4, 3'b100, good_crc(32'd3, 32'd4, 3'b100), 1'b0, 20);
    any_both |= r_both;
    expect_good("drop_hold", 32'h0000_0007, 4'b0000);
    check("drop_hold_idle_C", 64'(C), 64'd7);

    check("never_both", 64'(any_both), 64'd0);

    // Reset asserted while the core is in EXEC.
    A = 32'd10; B = 32'd20; op = 3'b100; data_err = 1'b0;
    crc_in = good_crc(32'd10, 32'd20, 3'b100);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_C",       64'(C), 64'd0);
    check("mid_rst_flags",   64'({carry, overflow, zero, negative}), 64'd0);
    check("mid_rst_crc",     64'(crc_out), 64'd0);
    check("mid_rst_ef",      64'(err_flags), 64'd0);
    check("mid_rst_strobes", 64'({t_valid, err_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    nt_rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (t_valid || err_valid) nt_rst++;
    end
    check("post_rst_strobes", 64'(nt_rst), 64'd0);
    check("post_rst_ready",   64'(in_ready), 64'd1);
    check("post_rst_C",       64'(C), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
